hazard_scoreboard: RTL and testbench

Pipeline hazard unit for the five-stage MIPS core. It consumes the per-instruction hazard descriptors the D-stage decoder produces: register numbers, Tuse, Tnew, write destination and forward-data kind. It keeps its own E/M/W scoreboard of in-flight writers, with Tnew aging each cycle, and drives the stall request and every forwarding-mux select in the datapath. The decoder is the producer of this interface; this block is its consumer.

---
 rtl/hazard_scoreboard.sv | 150 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the five-stage core: tracks in-flight writers in E/M/W,
// raises the D-stage stall and drives every forwarding-mux select.
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_dst,
    input  logic [1:0] D_Tnew,
    input  logic [2:0] D_FwSel,
    output logic       stall,
    output logic [1:0] FwD_rs,
    output logic [1:0] FwD_rt,
    output logic [1:0] FwE_rs,
    output logic [1:0] FwE_rt,
    output logic [1:0] FwM_rt,
    output logic [2:0] E_FwSel,
    output logic [2:0] M_FwSel,
    output logic [2:0] W_FwSel
);

    localparam logic [1:0] SRC_HOLD = 2'b00;
    localparam logic [1:0] SRC_E    = 2'b01;
    localparam logic [1:0] SRC_M    = 2'b10;
    localparam logic [1:0] SRC_W    = 2'b11;

    logic [4:0] E_rs_q, E_rs_d;
    logic [4:0] E_rt_q, E_rt_d;
    logic [4:0] E_dst_q, E_dst_d;
    logic [1:0] E_Tnew_q, E_Tnew_d;
    logic [2:0] E_FwSel_q, E_FwSel_d;

    logic [4:0] M_rt_q, M_rt_d;
    logic [4:0] M_dst_q, M_dst_d;
    logic [1:0] M_Tnew_q, M_Tnew_d;
    logic [2:0] M_FwSel_q, M_FwSel_d;

    logic [4:0] W_dst_q, W_dst_d;
    logic [2:0] W_FwSel_q, W_FwSel_d;

    logic stall_rs;
    logic stall_rt;

    logic e_match_rs, m_match_rs, w_match_rs;
    logic e_match_rt, m_match_rt, w_match_rt;

    // Register 0 is hardwired, so it never participates in a match.
    always_comb begin
        e_match_rs = (D_rs != 5'd0) && (E_dst_q == D_rs);
        m_match_rs = (D_rs != 5'd0) && (M_dst_q == D_rs);
        w_match_rs = (D_rs != 5'd0) && (W_dst_q == D_rs);
        e_match_rt = (D_rt != 5'd0) && (E_dst_q == D_rt);
        m_match_rt = (D_rt != 5'd0) && (M_dst_q == D_rt);
        w_match_rt = (D_rt != 5'd0) && (W_dst_q == D_rt);
    end

    // A hazard exists when the producer's result is not ready before the
    // consumer needs it; Tuse = 3 can never be below a Tnew of at most 2.
    always_comb begin
        stall_rs = (e_match_rs && (D_Tuse_rs < E_Tnew_q)) ||
                   (m_match_rs && (D_Tuse_rs < M_Tnew_q));
        stall_rt = (e_match_rt && (D_Tuse_rt < E_Tnew_q)) ||
                   (m_match_rt && (D_Tuse_rt < M_Tnew_q));
        stall    = stall_rs | stall_rt;
    end

    always_comb begin
        FwD_rs = SRC_HOLD;
        if (e_match_rs)      FwD_rs = SRC_E;
        else if (m_match_rs) FwD_rs = SRC_M;
        else if (w_match_rs) FwD_rs = SRC_W;

        FwD_rt = SRC_HOLD;
        if (e_match_rt)      FwD_rt = SRC_E;
        else if (m_match_rt) FwD_rt = SRC_M;
        else if (w_match_rt) FwD_rt = SRC_W;
    end

    always_comb begin
        FwE_rs = SRC_HOLD;
        if ((E_rs_q != 5'd0) && (M_dst_q == E_rs_q))      FwE_rs = SRC_M;
        else if ((E_rs_q != 5'd0) && (W_dst_q == E_rs_q)) FwE_rs = SRC_W;

        FwE_rt = SRC_HOLD;
        if ((E_rt_q != 5'd0) && (M_dst_q == E_rt_q))      FwE_rt = SRC_M;
        else if ((E_rt_q != 5'd0) && (W_dst_q == E_rt_q)) FwE_rt = SRC_W;

        FwM_rt = SRC_HOLD;
        if ((M_rt_q != 5'd0) && (W_dst_q == M_rt_q))      FwM_rt = SRC_W;
    end

    // Stall only bubbles E; M and W keep draining so the hazard clears.
    always_comb begin
        E_rs_d    = D_rs;
        E_rt_d    = D_rt;
        E_dst_d   = D_dst;
        E_Tnew_d  = D_Tnew;
        E_FwSel_d = D_FwSel;
        if (stall) begin
            E_rs_d    = 5'd0;
            E_rt_d    = 5'd0;
            E_dst_d   = 5'd0;
            E_Tnew_d  = 2'd0;
            E_FwSel_d = 3'd0;
        end

        M_rt_d    = E_rt_q;
        M_dst_d   = E_dst_q;
        M_Tnew_d  = (E_Tnew_q == 2'd0) ? 2'd0 : E_Tnew_q - 2'd1;
        M_FwSel_d = E_FwSel_q;

        W_dst_d   = M_dst_q;
        W_FwSel_d = M_FwSel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_rs_q    <= 5'd0;
            E_rt_q    <= 5'd0;
            E_dst_q   <= 5'd0;
            E_Tnew_q  <= 2'd0;
            E_FwSel_q <= 3'd0;
            M_rt_q    <= 5'd0;
            M_dst_q   <= 5'd0;
            M_Tnew_q  <= 2'd0;
            M_FwSel_q <= 3'd0;
            W_dst_q   <= 5'd0;
            W_FwSel_q <= 3'd0;
        end else begin
            E_rs_q    <= E_rs_d;
            E_rt_q    <= E_rt_d;
            E_dst_q   <= E_dst_d;
            E_Tnew_q  <= E_Tnew_d;
            E_FwSel_q <= E_FwSel_d;
            M_rt_q    <= M_rt_d;
            M_dst_q   <= M_dst_d;
            M_Tnew_q  <= M_Tnew_d;
            M_FwSel_q <= M_FwSel_d;
            W_dst_q   <= W_dst_d;
            W_FwSel_q <= W_FwSel_d;
        end
    end

    assign E_FwSel = E_FwSel_q;
    assign M_FwSel = M_FwSel_q;
    assign W_FwSel = W_FwSel_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random traffic,
// checked every cycle against an in-flight instruction list model.
module tb_hazard_scoreboard;

    localparam logic [2:0] FS_PC8 = 3'd1;
    localparam logic [2:0] FS_ALU = 3'd2;
    localparam logic [2:0] FS_DM  = 3'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] D_rs = '0, D_rt = '0, D_dst = '0;
    logic [1:0] D_Tuse_rs = 2'd3, D_Tuse_rt = 2'd3, D_Tnew = '0;
    logic [2:0] D_FwSel = '0;
    logic       stall;
    logic [1:0] FwD_rs, FwD_rt, FwE_rs, FwE_rt, FwM_rt;
    logic [2:0] E_FwSel, M_FwSel, W_FwSel;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_dst(D_dst), .D_Tnew(D_Tnew), .D_FwSel(D_FwSel),
        .stall(stall), .FwD_rs(FwD_rs), .FwD_rt(FwD_rt),
        .FwE_rs(FwE_rs), .FwE_rt(FwE_rt), .FwM_rt(FwM_rt),
        .E_FwSel(E_FwSel), .M_FwSel(M_FwSel), .W_FwSel(W_FwSel)
    );

    always #5 clk = ~clk;

    // Model: list of instructions in flight, index 0 = E, 1 = M, 2 = W.
    // Tnew is stored as issued; remaining time is derived from the age.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [2:0] fws;
    } ent_t;

    ent_t pipe [3];

    function automatic int remaining(input int k);
        int t;
        t = int'(pipe[k].tnew) - k;
        return (t > 0) ? t : 0;
    endfunction

    function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse);
        for (int k = 0; k < 2; k++)
            if (r != 0 && pipe[k].dst == r && int'(tuse) < remaining(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_stall();
        return op_stall(D_rs, D_Tuse_rs) || op_stall(D_rt, D_Tuse_rt);
    endfunction

    // Youngest matching stage at or after 'from'; code is stage index + 1.
    function automatic logic [1:0] fw(input logic [4:0] r, input int from);
        for (int k = from; k < 3; k++)
            if (r != 0 && pipe[k].dst == r) return 2'(k + 1);
        return 2'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe[0] <= '0;
            pipe[1] <= '0;
            pipe[2] <= '0;
        end else begin
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            pipe[0] <= model_stall() ? ent_t'('0)
                     : ent_t'{D_rs, D_rt, D_dst, D_Tnew, D_FwSel};
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_stall",   8'(stall),   8'(model_stall()));
            chk("m_FwD_rs",  8'(FwD_rs),  8'(fw(D_rs, 0)));
            chk("m_FwD_rt",  8'(FwD_rt),  8'(fw(D_rt, 0)));
            chk("m_FwE_rs",  8'(FwE_rs),  8'(fw(pipe[0].rs, 1)));
            chk("m_FwE_rt",  8'(FwE_rt),  8'(fw(pipe[0].rt, 1)));
            chk("m_FwM_rt",  8'(FwM_rt),  8'(fw(pipe[1].rt, 2)));
            chk("m_E_FwSel", 8'(E_FwSel), 8'(pipe[0].fws));
            chk("m_M_FwSel", 8'(M_FwSel), 8'(pipe[1].fws));
            chk("m_W_FwSel", 8'(W_FwSel), 8'(pipe[2].fws));
        end
    end

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tur, input logic [1:0] tut,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic [2:0] fws);
        D_rs = rs; D_rt = rt; D_Tuse_rs = tur; D_Tuse_rt = tut;
        D_dst = dst; D_Tnew = tnew; D_FwSel = fws;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 3'd0);
        repeat (n) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 8'(stall), 8'd0);
        chk({tag, "_FwD"},   8'({FwD_rs, FwD_rt}), 8'd0);
        chk({tag, "_FwE"},   8'({FwE_rs, FwE_rt}), 8'd0);
        chk({tag, "_FwM"},   8'(FwM_rt), 8'd0);
        chk({tag, "_FwSel"}, 8'(E_FwSel | M_FwSel | W_FwSel), 8'd0);
    endtask

    initial begin
        // Reset held with a load sitting in D.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, FS_DM);
        #1 cmp_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk_all_zero("rst");
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_E_FwSel", 8'(E_FwSel), 8'(FS_DM));
        tick();
        nops(3);

        // Load-use: one stall cycle, then forward from W in E.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, FS_DM);
        tick();
        set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, FS_ALU);
        @(negedge clk);
        chk("lu_stall1", 8'(stall), 8'd1);
        tick();
        @(negedge clk);
        chk("lu_stall2", 8'(stall), 8'd0);
        chk("lu_FwD_rs", 8'(FwD_rs), 8'd2);
        tick();
        nops(0);
        @(negedge clk);
        chk("lu_FwE_rs", 8'(FwE_rs), 8'd3);
        chk("lu_W_FwSel", 8'(W_FwSel), 8'(FS_DM));
        tick();
        nops(3);

        // ALU result into a Tuse-0 branch.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, FS_ALU);
        tick();
        set_d(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 3'd0);
        @(negedge clk);
        chk("ab_stall1", 8'(stall), 8'd1);
        tick();
        @(negedge clk);
        chk("ab_stall2", 8'(stall), 8'd0);
        chk("ab_FwD_rs", 8'(FwD_rs), 8'd2);
        chk("ab_M_FwSel", 8'(M_FwSel), 8'(FS_ALU));
        tick();
        nops(3);

        // Load into a branch: two stall cycles.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd2, FS_DM);
        tick();
        set_d(5'd12, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 3'd0);
        @(negedge clk); chk("lb_stall1", 8'(stall), 8'd1);
        tick();
        @(negedge clk); chk("lb_stall2", 8'(stall), 8'd1);
        tick();
        @(negedge clk); chk("lb_stall3", 8'(stall), 8'd0);
        chk("lb_FwD_rs", 8'(FwD_rs), 8'd3);
        tick();
        nops(3);

        // jal then jr: pc+8 is ready in E, no stall.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, FS_PC8);
        tick();
        set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 3'd0);
        @(negedge clk);
        chk("jj_stall", 8'(stall), 8'd0);
        chk("jj_FwD_rs", 8'(FwD_rs), 8'd1);
        chk("jj_E_FwSel", 8'(E_FwSel), 8'(FS_PC8));
        tick();
        nops(3);

        // Writer to $0 never creates a dependency.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, FS_ALU);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 3'd0);
        @(negedge clk);
        chk("z_stall", 8'(stall), 8'd0);
        chk("z_FwD", 8'({FwD_rs, FwD_rt}), 8'd0);
        tick();
        nops(3);

        // Reset pulse in the middle of a load-use stall.
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, FS_DM);
        tick();
        set_d(5'd8, 5'd8, 2'd1, 2'd1, 5'd10, 2'd1, FS_ALU);
        @(negedge clk);
        chk("ms_stall_pre", 8'(stall), 8'd1);
        #1 reset = 1'b0;
        #1 chk_all_zero("ms");
        #1 reset = 1'b1;
        tick();
        @(negedge clk);
        chk("ms_E_FwSel", 8'(E_FwSel), 8'(FS_ALU));
        tick();
        nops(3);

        // Random traffic over a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  3'($urandom_range(0, 7)));
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
